instr_fetch: RTL and testbench

//   Instruction fetch unit: owns the PC, issues word reads to instruction memory and feeds
//   the decoder one 32-bit instruction at a time over a valid/ready handshake.

---
 rtl/my_risc_pkg.sv | 17 +
 rtl/instr_queue.sv | 64 ++++++
 rtl/instr_fetch.sv | 133 +++++++++++++
 tb/tb_instr_fetch.sv | 526 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_risc_pkg.sv
// Shared fetch-side types and constants for the my_risc core.
package my_risc_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] pc_t;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam pc_t             RESET_PC_DEFAULT = 32'h0000_0000;

    // One decoded-side queue entry: the word and the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        pc_t             pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_queue.sv
// Small synchronous FIFO of fetched instructions with flush, count and full/empty.
module instr_queue
    import my_risc_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  fetch_entry_t                 din,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= din;
    end

    push_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                    !(push && full && !pop));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, credit-limited imem requests, in-order response queue, redirect/drop.
// Optional build macro IFETCH_MISALIGN_CHK_EN halts fetch on an unaligned redirect target.
module instr_fetch
    import my_risc_pkg::*;
#(
    parameter pc_t         RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_misalign
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned SW = CW + 1;

    pc_t           pc_q, pc_d;
    pc_t           rsp_pc_q, rsp_pc_d;
    pc_t           last_pc_q;
    pc_t           redirect_tgt;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [SW-1:0] inflight;
    logic          running_q;
    logic          halted;
    logic          credit_ok;
    logic          req_fire;
    logic          rsp_drop;

    logic          q_push, q_pop, q_full, q_empty;
    logic [CW-1:0] q_count;
    fetch_entry_t  q_din, q_head;

    instr_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (q_push),
        .din   (q_din),
        .pop   (q_pop),
        .flush (redirect_valid),
        .head  (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

`ifdef IFETCH_MISALIGN_CHK_EN
    logic halted_q;
    logic misalign_q;

    // An unaligned target parks the fetcher until the next aligned redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) halted_q <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign halted         = halted_q;
    assign fetch_misalign = misalign_q;
    assign redirect_tgt   = redirect_pc;
`else
    assign halted         = 1'b0;
    assign fetch_misalign = 1'b0;
    assign redirect_tgt   = redirect_pc & 32'hFFFF_FFFC;
`endif

    // Issue, response accounting and redirect bookkeeping.
    always_comb begin
        inflight       = {1'b0, outstanding_q} + {1'b0, q_count};
        credit_ok      = !q_full && (inflight < SW'(QDEPTH));
        imem_req_valid = running_q && credit_ok && !redirect_valid && !halted;
        req_fire       = imem_req_valid && imem_req_ready;

        rsp_drop = imem_rsp_valid && (drop_q != '0);
        q_push   = imem_rsp_valid && (drop_q == '0);
        q_din    = '{instr: imem_rsp_data, pc: rsp_pc_q};
        q_pop    = instr_valid && instr_ready;

        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);

        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        drop_d   = drop_q;
        if (redirect_valid) begin
            pc_d     = redirect_tgt;
            rsp_pc_d = redirect_tgt;
            drop_d   = outstanding_d;
        end else begin
            if (req_fire) pc_d     = pc_q + 32'd4;
            if (q_push)   rsp_pc_d = rsp_pc_q + 32'd4;
            if (rsp_drop) drop_d   = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            last_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            running_q     <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            running_q     <= 1'b1;
            if (instr_valid) last_pc_q <= q_head.pc;
        end
    end

    assign imem_req_addr = pc_q;
    assign instr_valid   = !q_empty && !halted;
    assign instr         = instr_valid ? q_head.instr : NOP_INSTR;
    assign instr_pc      = instr_valid ? q_head.pc : last_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: imem model plus a program-order reference of the fetch stream.
module tb_instr_fetch;
    import my_risc_pkg::*;

    localparam int unsigned QD  = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_misalign;

    instr_fetch #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_misalign (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int ready_pct  = 100;
    int rsp_pct    = 100;
    int iready_pct = 100;
    int lat_max    = 1;

    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];

    typedef enum {EV_ACC, EV_POP, EV_RSP, EV_RDR, EV_MIS} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } ev_t;
    ev_t ev_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock of stimulus: drive at negedge, record handshakes just before posedge.
    task automatic cycle(input bit redir, input logic [31:0] rpc);
        int due;
        @(negedge clk);
        imem_req_ready = ($urandom_range(1, 100) <= ready_pct);
        if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc && $urandom_range(1, 100) <= rsp_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr_q[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom();
        end
        instr_ready    = ($urandom_range(1, 100) <= iready_pct);
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        if (fetch_misalign) ev_q.push_back('{EV_MIS, 32'h0, 32'h0, cyc});
        if (instr_valid && instr_ready) ev_q.push_back('{EV_POP, instr_pc, instr, cyc});
        if (imem_rsp_valid) begin
            ev_q.push_back('{EV_RSP, mem_addr_q[0], imem_rsp_data, cyc});
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
            ev_q.push_back('{EV_ACC, imem_req_addr, 32'h0, cyc});
            due = cyc + $urandom_range(1, lat_max);
            if (mem_due_q.size() > 0 && due < mem_due_q[$]) due = mem_due_q[$];
            mem_addr_q.push_back(imem_req_addr);
            mem_due_q.push_back(due);
        end
        if (redir) ev_q.push_back('{EV_RDR, rpc, {31'h0, imem_req_valid}, cyc});
        @(posedge clk);
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_addr_q.delete();
        mem_due_q.delete();
        ev_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference: decoder sees consecutive words from the last redirect target; requests likewise.
    function automatic void ref_walk(output int n_pop, output int bad_pop,
                                     output int n_acc, output int bad_acc);
        logic [31:0] ep, ea, tgt;
        bit          halted;
        ep = RPC; ea = RPC; halted = 1'b0;
        n_pop = 0; bad_pop = 0; n_acc = 0; bad_acc = 0;
        foreach (ev_q[i]) begin
            case (ev_q[i].kind)
                EV_POP: begin
                    n_pop++;
                    if (halted || ev_q[i].a !== ep || ev_q[i].d !== mem_word(ep)) bad_pop++;
                    ep = ep + 32'd4;
                end
                EV_ACC: begin
                    n_acc++;
                    if (halted || ev_q[i].a !== ea) bad_acc++;
                    ea = ea + 32'd4;
                end
                EV_RDR: begin
`ifdef IFETCH_MISALIGN_CHK_EN
                    tgt    = ev_q[i].a;
                    halted = (tgt[1:0] != 2'b00);
`else
                    tgt = ev_q[i].a & 32'hFFFF_FFFC;
`endif
                    if (ev_q[i].d[0]) bad_acc++;
                    ep = tgt;
                    ea = tgt;
                end
                default: ;
            endcase
        end
    endfunction

    function automatic bit ev_find(input ev_kind_t k, input int after, input int n,
                                   output logic [31:0] a, output int c);
        int seen = 0;
        a = 'x; c = -1;
        foreach (ev_q[i]) begin
            if (i > after && ev_q[i].kind == k) begin
                if (seen == n) begin
                    a = ev_q[i].a;
                    c = ev_q[i].c;
                    return 1'b1;
                end
                seen++;
            end
        end
        return 1'b0;
    endfunction

    function automatic int count_kind(input ev_kind_t k, input int after);
        int n = 0;
        foreach (ev_q[i]) if (i > after && ev_q[i].kind == k) n++;
        return n;
    endfunction

    function automatic int rdr_index(input int n);
        int seen = 0;
        foreach (ev_q[i]) begin
            if (ev_q[i].kind == EV_RDR) begin
                if (seen == n) return i;
                seen++;
            end
        end
        return -1;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({imem_req_valid, instr_valid, fetch_misalign} !== 3'b000) begin
            failures++;
            $display("FAIL reset_valids got=%b exp=000", {imem_req_valid, instr_valid, fetch_misalign});
        end
        checks++;
        if (imem_req_addr !== RPC) begin
            failures++;
            $display("FAIL reset_req_addr got=%h exp=%h", imem_req_addr, RPC);
        end
        checks++;
        if (instr !== NOP) begin
            failures++;
            $display("FAIL reset_instr got=%h exp=%h", instr, NOP);
        end
        checks++;
        if (instr_pc !== RPC) begin
            failures++;
            $display("FAIL reset_instr_pc got=%h exp=%h", instr_pc, RPC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] a, ra;
        int c, rc, np, bp, na, ba;
        bit f, rf;
        apply_reset();
        ready_pct = 100; rsp_pct = 100; iready_pct = 100; lat_max = 1;
        repeat (14) cycle(1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            f = ev_find(EV_ACC, -1, k, a, c);
            checks++;
            if (!f || a !== RPC + 32'(4 * k)) begin
                failures++;
                $display("FAIL seq_req_addr%0d got=%h exp=%h", k, a, RPC + 32'(4 * k));
            end
            f  = ev_find(EV_POP, -1, k, a, c);
            rf = ev_find(EV_RSP, -1, k, ra, rc);
            checks++;
            if (!f || !rf || a !== RPC + 32'(4 * k) || c !== rc + 1) begin
                failures++;
                $display("FAIL seq_instr%0d got_pc=%h got_cyc=%0d exp_pc=%h exp_cyc=%0d",
                         k, a, c, RPC + 32'(4 * k), rc + 1);
            end
        end
        ref_walk(np, bp, na, ba);
        checks++;
        if (bp !== 0 || ba !== 0) begin
            failures++;
            $display("FAIL seq_stream got_bad=%0d/%0d exp=0/0", bp, ba);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] first_instr;
        bit seen, stable;
        int np, bp, na, ba;
        apply_reset();
        ready_pct = 100; rsp_pct = 100; iready_pct = 0; lat_max = 1;
        seen = 1'b0; stable = 1'b1; first_instr = '0;
        repeat (10) begin
            cycle(1'b0, 32'h0);
            #1;
            if (instr_valid) begin
                if (!seen) begin
                    first_instr = instr;
                    seen = 1'b1;
                end else if (instr !== first_instr) begin
                    stable = 1'b0;
                end
            end
        end
        checks++;
        if (count_kind(EV_ACC, -1) !== QD) begin
            failures++;
            $display("FAIL bp_requests got=%0d exp=%0d", count_kind(EV_ACC, -1), QD);
        end
        checks++;
        if (!seen || !stable || first_instr !== mem_word(RPC)) begin
            failures++;
            $display("FAIL bp_instr_hold got=%h seen=%0d stable=%0d exp=%h",
                     first_instr, seen, stable, mem_word(RPC));
        end
        iready_pct = 100;
        repeat (10) cycle(1'b0, 32'h0);
        ready_pct = 0;
        repeat (8) cycle(1'b0, 32'h0);
        ref_walk(np, bp, na, ba);
        checks++;
        if (bp !== 0 || ba !== 0 || np !== na || np < 4) begin
            failures++;
            $display("FAIL bp_drain got_pops=%0d reqs=%0d bad=%0d/%0d exp_pops=%0d",
                     np, na, bp, ba, na);
        end
    endtask

    task automatic test_redirect_drop();
        logic [31:0] a;
        int c, ri, np, bp, na, ba;
        bit f;
        apply_reset();
        ready_pct = 100; rsp_pct = 0; iready_pct = 100; lat_max = 1;
        for (int i = 0; i < 10 && count_kind(EV_ACC, -1) < 2; i++) cycle(1'b0, 32'h0);
        checks++;
        if (count_kind(EV_ACC, -1) !== 2) begin
            failures++;
            $display("FAIL drop_setup got=%0d exp=2", count_kind(EV_ACC, -1));
        end
        cycle(1'b1, 32'h100);
        rsp_pct = 100;
        repeat (14) cycle(1'b0, 32'h0);
        ri = rdr_index(0);
        f  = ev_find(EV_POP, ri, 0, a, c);
        ref_walk(np, bp, na, ba);
        checks++;
        if (!f || a !== 32'h100 || bp !== 0 || ba !== 0) begin
            failures++;
            $display("FAIL drop_first_pc got=%h bad=%0d/%0d exp=00000100", a, bp, ba);
        end

        apply_reset();
        ready_pct = 100; rsp_pct = 100; iready_pct = 0; lat_max = 1;
        repeat (6) cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h200);
        iready_pct = 100;
        repeat (10) cycle(1'b0, 32'h0);
        ri = rdr_index(0);
        f  = ev_find(EV_POP, -1, 0, a, c);
        ref_walk(np, bp, na, ba);
        checks++;
        if (!f || a !== 32'h200 || bp !== 0 || ba !== 0 || ri < 0) begin
            failures++;
            $display("FAIL flush_first_pc got=%h bad=%0d/%0d exp=00000200", a, bp, ba);
        end
    endtask

    task automatic test_redirect_collide();
        logic [31:0] a;
        int c, ri, np, bp, na, ba;
        bit f, hit;
        apply_reset();
        ready_pct = 100; rsp_pct = 100; iready_pct = 100; lat_max = 2;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (i > 3 && mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
                cycle(1'b1, 32'h300);
                hit = 1'b1;
            end else begin
                cycle(1'b0, 32'h0);
            end
        end
        repeat (12) cycle(1'b0, 32'h0);
        ri = rdr_index(0);
        f  = ev_find(EV_POP, ri, 0, a, c);
        ref_walk(np, bp, na, ba);
        checks++;
        if (!hit || !f || a !== 32'h300 || bp !== 0 || ba !== 0) begin
            failures++;
            $display("FAIL collide got_pc=%h hit=%0d bad=%0d/%0d exp_pc=00000300", a, hit, bp, ba);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] a, exp;
        int c, ri, np, bp, na, ba;
        bit f;
        apply_reset();
        ready_pct = 100; rsp_pct = 100; iready_pct = 100; lat_max = 1;
        cycle(1'b1, 32'hFFFF_FFF8);
        repeat (14) cycle(1'b0, 32'h0);
        ri  = rdr_index(0);
        exp = 32'hFFFF_FFF8;
        for (int k = 0; k < 3; k++) begin
            f = ev_find(EV_ACC, ri, k, a, c);
            checks++;
            if (!f || a !== exp) begin
                failures++;
                $display("FAIL wrap_addr%0d got=%h exp=%h", k, a, exp);
            end
            exp = exp + 32'd4;
        end
        ref_walk(np, bp, na, ba);
        checks++;
        if (bp !== 0 || ba !== 0 || np < 3) begin
            failures++;
            $display("FAIL wrap_stream got_pops=%0d bad=%0d/%0d exp_bad=0/0", np, bp, ba);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] a;
        int c, ri, np, bp, na, ba;
        bit f;
        apply_reset();
        ready_pct = 100; rsp_pct = 100; iready_pct = 100; lat_max = 1;
        repeat (4) cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h102);
        repeat (10) cycle(1'b0, 32'h0);
        ri = rdr_index(0);
`ifdef IFETCH_MISALIGN_CHK_EN
        checks++;
        if (count_kind(EV_MIS, -1) !== 1 || count_kind(EV_ACC, ri) !== 0) begin
            failures++;
            $display("FAIL misalign_halt got_pulses=%0d reqs=%0d exp=1/0",
                     count_kind(EV_MIS, -1), count_kind(EV_ACC, ri));
        end
        #1;
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL misalign_instr_valid got=%b exp=0", instr_valid);
        end
        cycle(1'b1, 32'h200);
        repeat (10) cycle(1'b0, 32'h0);
        f = ev_find(EV_POP, rdr_index(1), 0, a, c);
        checks++;
        if (!f || a !== 32'h200) begin
            failures++;
            $display("FAIL misalign_resume got=%h exp=00000200", a);
        end
`else
        f = ev_find(EV_ACC, ri, 0, a, c);
        checks++;
        if (!f || a !== 32'h100 || count_kind(EV_MIS, -1) !== 0) begin
            failures++;
            $display("FAIL misalign_forced got=%h pulses=%0d exp=00000100/0",
                     a, count_kind(EV_MIS, -1));
        end
        f = ev_find(EV_POP, ri, 0, a, c);
        checks++;
        if (!f || a !== 32'h100) begin
            failures++;
            $display("FAIL misalign_first_pc got=%h exp=00000100", a);
        end
`endif
        ref_walk(np, bp, na, ba);
        checks++;
        if (bp !== 0 || ba !== 0) begin
            failures++;
            $display("FAIL misalign_stream got_bad=%0d/%0d exp=0/0", bp, ba);
        end
    endtask

    task automatic test_reset_midstream();
        int np, bp, na, ba;
        apply_reset();
        ready_pct = 80; rsp_pct = 80; iready_pct = 50; lat_max = 2;
        repeat (15) cycle(1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        #1;
        checks++;
        if ({imem_req_valid, instr_valid, fetch_misalign} !== 3'b000 || instr !== NOP ||
            instr_pc !== RPC || imem_req_addr !== RPC) begin
            failures++;
            $display("FAIL midreset_outputs got=%b/%h/%h/%h exp=000/%h/%h/%h",
                     {imem_req_valid, instr_valid, fetch_misalign}, instr, instr_pc,
                     imem_req_addr, NOP, RPC, RPC);
        end
        mem_addr_q.delete();
        mem_due_q.delete();
        ev_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (16) cycle(1'b0, 32'h0);
        ref_walk(np, bp, na, ba);
        checks++;
        if (bp !== 0 || ba !== 0 || np < 1) begin
            failures++;
            $display("FAIL midreset_restart got_pops=%0d bad=%0d/%0d exp_bad=0/0", np, bp, ba);
        end
    endtask

    task automatic test_random();
        int np, bp, na, ba, lr;
        logic [31:0] tgt;
        bit redir;
        apply_reset();
        ready_pct = 70; rsp_pct = 70; iready_pct = 60; lat_max = 3;
        for (int i = 0; i < 600; i++) begin
            redir = ($urandom_range(1, 100) <= 4);
`ifdef IFETCH_MISALIGN_CHK_EN
            tgt = $urandom() & 32'hFFFF_FFFC;
`else
            tgt = $urandom();
`endif
            cycle(redir, tgt);
        end
        ready_pct = 0; rsp_pct = 100; iready_pct = 100;
        repeat (14) cycle(1'b0, 32'h0);
        ref_walk(np, bp, na, ba);
        checks++;
        if (bp !== 0 || ba !== 0 || np < 100) begin
            failures++;
            $display("FAIL random_stream got_pops=%0d bad=%0d/%0d exp_bad=0/0", np, bp, ba);
        end
        lr = rdr_index(count_kind(EV_RDR, -1) - 1);
        checks++;
        if (count_kind(EV_POP, lr) !== count_kind(EV_ACC, lr)) begin
            failures++;
            $display("FAIL random_no_loss got_pops=%0d exp=%0d",
                     count_kind(EV_POP, lr), count_kind(EV_ACC, lr));
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_drop();
        test_redirect_collide();
        test_wrap();
        test_misalign();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
